// File: rtl/button_debounce_if.sv
// ----------------------------------------------------------------------------
// button_debounce_if
//   Bundles the button pins and the debounced outputs of button_debounce.
//   Signals (all active-low levels unless noted, 8 channels):
//     btn_raw      raw asynchronous button pins (0 = pressed)
//     btn          debounced button levels (0 = pressed)
//     press        one-cycle pulse per accepted press (and auto-repeat)
//     btn_release  one-cycle pulse per accepted release
//     any_pressed  high while any debounced button is pressed
//   Modports: master = pin/consumer side, slave = the debouncer.
// ----------------------------------------------------------------------------
interface button_debounce_if;
  logic [7:0] btn_raw;
  logic [7:0] btn;
  logic [7:0] press;
  logic [7:0] btn_release;
  logic       any_pressed;

  modport master (output btn_raw, input btn, press, btn_release, any_pressed);
  modport slave  (input btn_raw, output btn, press, btn_release, any_pressed);
endinterface

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Eight independent debounce channels for active-low push buttons.
//   Each raw pin goes through a two-flop synchronizer; a per-channel counter
//   must see DEBOUNCE_CYCLES consecutive synchronized cycles differing from the
//   current debounced level before that level flips. Flip edges produce
//   one-cycle press/release pulses. A raw change reaches btn after exactly
//   2+DEBOUNCE_CYCLES clocks.
//
//   Optional feature (macro BTN_DEBOUNCE_AUTOREPEAT_EN): while a button stays
//   pressed, press re-pulses REPEAT_DELAY cycles after the accepted press and
//   every REPEAT_PERIOD cycles after that. Without the macro no repeat logic
//   exists and REPEAT_DELAY / REPEAT_PERIOD are ignored.
//
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   button_debounce_if.slave (btn_raw in; btn, press, btn_release,
//           any_pressed out)
// ----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned REPEAT_DELAY    = 24000000,
  parameter int unsigned REPEAT_PERIOD   = 4800000
) (
  input  logic             clk,
  input  logic             rst,
  button_debounce_if.slave bus
);

  localparam int NCH = 8;
  // Counter only ever has to hold DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'd1048575 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_debounce: parameter out of range");
  end

  logic [NCH-1:0]         s1_q, s2_q;
  logic [NCH-1:0]         btn_q, btn_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]         press_q, press_d;
  logic [NCH-1:0]         rel_q, rel_d;
  logic                   any_q, any_d;

  // Debounce counters and debounced level.
  always_comb begin
    btn_d = btn_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (s2_q[i] == btn_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        btn_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        // Only reached below CNT_LAST, so the counter can never wrap.
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [NCH-1:0][RW-1:0] rep_q, rep_d;
  // Set once the first (REPEAT_DELAY) repeat has fired; later ones use the period.
  logic [NCH-1:0]         rfirst_q, rfirst_d;
  logic [NCH-1:0]         rfire;

  always_comb begin
    rep_d    = rep_q;
    rfirst_d = rfirst_q;
    rfire    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (btn_q[i] && !btn_d[i]) begin
        rep_d[i]    = '0;
        rfirst_d[i] = 1'b0;
      end else if (!btn_q[i] && !btn_d[i]) begin
        if (rep_q[i] == (rfirst_q[i] ? RP_LAST : RD_LAST)) begin
          rfire[i]    = 1'b1;
          rep_d[i]    = '0;
          rfirst_d[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + 1'b1;
        end
      end else begin
        rep_d[i]    = '0;
        rfirst_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q    <= '0;
      rfirst_q <= '0;
    end else begin
      rep_q    <= rep_d;
      rfirst_q <= rfirst_d;
    end
  end
`endif

  // Pulses and any_pressed are registered on the same edge as btn.
  always_comb begin
    press_d = btn_q & ~btn_d;
    rel_d   = ~btn_q & btn_d;
    any_d   = ~&btn_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    press_d = press_d | rfire;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '1;
      s2_q    <= '1;
      btn_q   <= '1;
      cnt_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      s1_q    <= bus.btn_raw;
      s2_q    <= s1_q;
      btn_q   <= btn_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      any_q   <= any_d;
    end
  end

  assign bus.btn         = btn_q;
  assign bus.press       = press_q;
  assign bus.btn_release = rel_q;
  assign bus.any_pressed = any_q;

endmodule
